// File: rtl/nt_seq_trigger_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nt_seq_trigger_monitor: serial pattern matcher, saturating hit counter,   |
// | sticky alarm, 4-phase clear handshake.            Revision: 1.0           |
// +----------------------------------------------------------------------------+
module nt_seq_trigger_monitor #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  parameter int                 THRESH  = 3
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             alarm
);

  localparam int                   c_fill_w    = $clog2(PAT_LEN + 1);
  localparam logic [c_fill_w-1:0]  c_fill_full = c_fill_w'(PAT_LEN);
  localparam logic [c_fill_w-1:0]  c_fill_hit  = c_fill_w'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]     c_cnt_max   = '1;
  localparam logic [CNT_W-1:0]     c_thresh    = CNT_W'(THRESH);

  localparam logic [1:0] c_st_fill  = 2'd0;
  localparam logic [1:0] c_st_armed = 2'd1;
  localparam logic [1:0] c_st_alarm = 2'd2;
  localparam logic [1:0] c_st_clear = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PAT_LEN-2:0]  sr_q, sr_d;
  logic [c_fill_w-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                match_q, match_d;
  logic                alarm_q, alarm_d;
  logic                ack_q, ack_d;

  logic               w_accept;
  logic [PAT_LEN-1:0] w_window;
  logic               w_hit;

  // Only the newest PAT_LEN-1 bits are stored; the current beat completes the window.
  assign w_accept = din_valid & (state_q != c_st_clear) & ~clr_req;
  assign w_window = {sr_q, din};
  assign w_hit    = w_accept & (fill_q >= c_fill_hit) & (w_window == PATTERN);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    if (clr_req || (state_q == c_st_clear)) begin
      state_d = clr_req ? c_st_clear : c_st_fill;
      sr_d    = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end else begin
      if (w_accept) begin
        sr_d = w_window[PAT_LEN-2:0];
        if (fill_q != c_fill_full) fill_d = fill_q + 1'b1;
      end
      if (w_hit) begin
        match_d = 1'b1;
        if (cnt_q != c_cnt_max) cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
        c_st_fill: begin
          if (fill_d == c_fill_full)
            state_d = (cnt_d >= c_thresh) ? c_st_alarm : c_st_armed;
        end
        c_st_armed: begin
          if (cnt_d >= c_thresh) state_d = c_st_alarm;
        end
        default: ;
      endcase
    end
    alarm_d = (state_d == c_st_alarm);
    ack_d   = (state_d == c_st_clear);
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state_q <= c_st_fill;
      sr_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      alarm_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      alarm_q <= alarm_d;
      ack_q   <= ack_d;
    end
  end

  assign clr_ack   = ack_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign alarm     = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_nt_seq_trigger_monitor.sv
`default_nettype none
// Bench for nt_seq_trigger_monitor: default instance and a 2-bit counter instance
// driven together, checked every cycle against a beat-history reference model.
module tb_nt_seq_trigger_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid, din, clr_req;
  logic       ack0, match0, alarm0;
  logic [7:0] cnt0;
  logic       ack1, match1, alarm1;
  logic [1:0] cnt1;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: beats seen since last reset/clear and total hits.
  int m_hist, m_nb, m_hits;
  bit m_match, m_ack;

  always #5 clk = ~clk;

  nt_seq_trigger_monitor u_dut0 (
    .I1470(clk), .I1477(rst_n), .din_valid(din_valid), .din(din), .clr_req(clr_req),
    .clr_ack(ack0), .match(match0), .match_cnt(cnt0), .alarm(alarm0)
  );

  nt_seq_trigger_monitor #(.CNT_W(2), .THRESH(3)) u_dut1 (
    .I1470(clk), .I1477(rst_n), .din_valid(din_valid), .din(din), .clr_req(clr_req),
    .clr_ack(ack1), .match(match1), .match_cnt(cnt1), .alarm(alarm1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_clear();
    m_hist = 0; m_nb = 0; m_hits = 0; m_match = 0; m_ack = 0;
  endfunction

  function automatic void model_edge();
    if (!rst_n) begin
      m_clear();
    end else if (clr_req || m_ack) begin
      m_hist = 0; m_nb = 0; m_hits = 0; m_match = 0;
      m_ack  = clr_req;
    end else begin
      m_match = 0;
      if (din_valid) begin
        m_hist = ((m_hist << 1) | int'(din)) & 15;
        if (m_nb < 4) m_nb++;
        if (m_nb >= 4 && m_hist == 'b1011) begin
          m_match = 1;
          m_hits++;
        end
      end
    end
  endfunction

  task automatic check_all();
    check("d0.match", int'(match0), int'(m_match));
    check("d0.cnt",   int'(cnt0),   (m_hits > 255) ? 255 : m_hits);
    check("d0.alarm", int'(alarm0), int'(m_hits >= 3));
    check("d0.ack",   int'(ack0),   int'(m_ack));
    check("d1.match", int'(match1), int'(m_match));
    check("d1.cnt",   int'(cnt1),   (m_hits > 3) ? 3 : m_hits);
    check("d1.alarm", int'(alarm1), int'(m_hits >= 3));
    check("d1.ack",   int'(ack1),   int'(m_ack));
  endtask

  task automatic step(input logic v, input logic d, input logic c);
    din_valid = v; din = d; clr_req = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic beats(input logic [15:0] bits, input int n, input int idle);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      for (int j = 0; j < idle; j++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Reset lands mid-cycle; outputs must drop before any further clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_clear();
    check_all();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int clr_left = 0;
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr_req = 1'b0;
    m_clear();
    #1;
    check_all();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    beats(16'b1011, 4, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    beats(16'b1011011, 7, 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    beats(16'b1011, 4, 2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);

    beats(16'b1011011011011, 13, 0);
    step(1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    beats(16'b1011, 4, 0);

    beats(16'b1011011011011011, 16, 0);
    async_reset();
    beats(16'b011, 3, 0);
    beats(16'b1011, 4, 1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic c;
      if (clr_left > 0) clr_left--;
      else if ($urandom_range(0, 99) < 2) clr_left = $urandom_range(1, 4);
      c = (clr_left > 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), c);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
